// File: rtl/logistic_seq_mc.sv
// logistic_seq_mc
//   Multi-channel streaming logistic-map bit generator. Each of N_CH lanes
//   iterates x' = 4x(1-x) in Q0.FRAC_W fixed point. After BURN_IN discarded
//   iterations, the MSB of every iterate is packed into OUT_W-bit words per
//   lane. The requested number of words is streamed over valid/ready.
//
//   Valid/ready contract (both interfaces): a transfer happens in a cycle
//   where vld and rdy are both high. A producer holds its data stable while
//   vld=1 and rdy=0.
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   seed          per-lane x0, lane i = seed[i*FRAC_W +: FRAC_W]
//   seed_words    number of words to produce (0 = run until abort)
//   seed_vld/rdy  seed handshake (rdy only in IDLE with no pending word)
//   abort         synchronous stop, back to IDLE, pending output dropped
//   dout          packed words, lane i = dout[i*OUT_W +: OUT_W]
//   dout_vld/rdy  output handshake
//   dout_last     marks the final word of a finite request
//   busy          high whenever the FSM is not in IDLE
module logistic_seq_mc #(
  parameter int FRAC_W  = 16,
  parameter int N_CH    = 2,
  parameter int OUT_W   = 32,
  parameter int BURN_IN = 100,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*FRAC_W-1:0]  seed,
  input  logic [CNT_W-1:0]        seed_words,
  input  logic                    seed_vld,
  output logic                    seed_rdy,
  input  logic                    abort,
  output logic [N_CH*OUT_W-1:0]   dout,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic                    dout_last,
  output logic                    busy
);

  localparam int BURN_CW = (BURN_IN > 0) ? $clog2(BURN_IN + 1) : 1;
  localparam int BIT_CW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [BURN_CW-1:0] BURN_LAST = BURN_CW'((BURN_IN > 0) ? BURN_IN - 1 : 0);
  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(OUT_W - 1);
  localparam logic [FRAC_W:0]    ONE       = {1'b1, {FRAC_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, BURN, GEN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [N_CH*FRAC_W-1:0]  x_q, x_next;
  logic [N_CH*OUT_W-1:0]   shift_q, word_next;
  logic [BURN_CW-1:0]      burn_cnt;
  logic [BIT_CW-1:0]       bit_cnt;
  logic [CNT_W-1:0]        word_cnt, words_q;

  logic load, iter, word_done, last_word, final_bit, accept;

  // Per-lane map step and the word as it would look with the new MSB added.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    logic [FRAC_W-1:0]   xi;
    logic [2*FRAC_W:0]   prod, scaled;
    assign xi     = x_q[i*FRAC_W +: FRAC_W];
    assign prod   = {{(FRAC_W+1){1'b0}}, xi} * {{FRAC_W{1'b0}}, ONE - {1'b0, xi}};
    assign scaled = prod >> (FRAC_W - 2);
    // Only x = 1/2 overflows (to exactly 1.0); clamp to the largest code.
    assign x_next[i*FRAC_W +: FRAC_W] = (|scaled[2*FRAC_W:FRAC_W]) ? {FRAC_W{1'b1}}
                                                                    : scaled[FRAC_W-1:0];
    assign word_next[i*OUT_W +: OUT_W] =
      OUT_W'({shift_q[i*OUT_W +: OUT_W], x_next[(i+1)*FRAC_W-1]});
  end

  assign seed_rdy  = (state_q == IDLE) && !dout_vld;
  assign busy      = (state_q != IDLE);
  assign final_bit = (bit_cnt == BIT_LAST);
  assign accept    = dout_vld && dout_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    iter      = 1'b0;
    word_done = 1'b0;
    last_word = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_vld && seed_rdy) begin
          load    = 1'b1;
          state_d = (BURN_IN == 0) ? GEN : BURN;
        end
      end
      BURN: begin
        iter = 1'b1;
        if (burn_cnt == BURN_LAST) state_d = GEN;
      end
      GEN: begin
        if (!final_bit) begin
          iter = 1'b1;
        end else if (!dout_vld || dout_rdy) begin
          // Completing bit of a word may only advance once the dout register
          // is free (or being freed this very cycle).
          iter      = 1'b1;
          word_done = 1'b1;
          if (words_q != '0 && (word_cnt + CNT_W'(1)) == words_q) begin
            last_word = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      load      = 1'b0;
      iter      = 1'b0;
      word_done = 1'b0;
      last_word = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      shift_q   <= '0;
      burn_cnt  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      words_q   <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
    end else if (abort) begin
      shift_q   <= '0;
      burn_cnt  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
    end else begin
      if (load) begin
        x_q      <= seed;
        words_q  <= seed_words;
        shift_q  <= '0;
        burn_cnt <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end
      if (iter) begin
        x_q <= x_next;
        if (state_q == BURN) begin
          burn_cnt <= (burn_cnt == BURN_LAST) ? '0 : burn_cnt + BURN_CW'(1);
        end else begin
          shift_q <= word_next;
          bit_cnt <= final_bit ? '0 : bit_cnt + BIT_CW'(1);
        end
      end
      if (word_done) begin
        dout      <= word_next;
        dout_vld  <= 1'b1;
        dout_last <= last_word;
        word_cnt  <= word_cnt + CNT_W'(1);
      end else if (accept) begin
        dout_vld  <= 1'b0;
        dout_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logistic_seq_mc.sv
// Testbench for logistic_seq_mc: a small instance (OUT_W=8, no burn-in) for
// the directed table and corner sequences, and a default instance
// (OUT_W=32, BURN_IN=100) for burn-in latency and data.
module tb_logistic_seq_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: FRAC_W=16, N_CH=2, OUT_W=8, BURN_IN=0
  logic [31:0] a_seed = '0;
  logic [15:0] a_words = '0;
  logic        a_seed_vld = 1'b0, a_seed_rdy;
  logic        a_abort = 1'b0;
  logic [15:0] a_dout;
  logic        a_dout_vld, a_dout_rdy = 1'b1, a_dout_last, a_busy;

  // Instance B: defaults
  logic [31:0] b_seed = '0;
  logic [15:0] b_words = '0;
  logic        b_seed_vld = 1'b0, b_seed_rdy;
  logic        b_abort = 1'b0;
  logic [63:0] b_dout;
  logic        b_dout_vld, b_dout_rdy = 1'b1, b_dout_last, b_busy;

  logistic_seq_mc #(.FRAC_W(16), .N_CH(2), .OUT_W(8), .BURN_IN(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed(a_seed), .seed_words(a_words),
    .seed_vld(a_seed_vld), .seed_rdy(a_seed_rdy), .abort(a_abort),
    .dout(a_dout), .dout_vld(a_dout_vld), .dout_rdy(a_dout_rdy),
    .dout_last(a_dout_last), .busy(a_busy)
  );

  logistic_seq_mc dut_b (
    .clk(clk), .rst_n(rst_n), .seed(b_seed), .seed_words(b_words),
    .seed_vld(b_seed_vld), .seed_rdy(b_seed_rdy), .abort(b_abort),
    .dout(b_dout), .dout_vld(b_dout_vld), .dout_rdy(b_dout_rdy),
    .dout_last(b_dout_last), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] seed;
    int          words;
    logic [15:0] exp_first;
    bit          poke;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference logistic step on a 16-bit state.
  function automatic logic [15:0] lstep(input logic [15:0] x);
    int unsigned xv, p;
    xv = 32'(x);
    p  = (xv * (32'd65536 - xv)) >> 14;
    return (p > 32'd65535) ? 16'hFFFF : p[15:0];
  endfunction

  task automatic gen_expected(input logic [31:0] sd, input int n, input int ow, input int burn);
    logic [15:0] m0, m1;
    logic [31:0] l0, l1;
    m0 = sd[15:0];
    m1 = sd[31:16];
    for (int k = 0; k < burn; k++) begin
      m0 = lstep(m0);
      m1 = lstep(m1);
    end
    for (int k = 0; k < n; k++) begin
      l0 = '0;
      l1 = '0;
      for (int b = 0; b < ow; b++) begin
        m0 = lstep(m0);
        m1 = lstep(m1);
        l0 = {l0[30:0], m0[15]};
        l1 = {l1[30:0], m1[15]};
      end
      exp_q.push_back((64'(l1) << ow) | 64'(l0));
    end
  endtask

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
    return exp_q.pop_front();
  endfunction

  task automatic wait_a_vld(output int lat);
    lat = 1;
    while (!a_dout_vld && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One finite request on instance A, checking latency, data, last, and
  // the return of seed_rdy. Optionally pokes a bogus seed while busy.
  task automatic run_a(input vec_t v);
    int lat, got;
    exp_q.delete();
    gen_expected(v.seed, v.words, 8, 0);
    chk("a_seed_rdy_idle", 64'(a_seed_rdy), 64'd1);
    a_seed = v.seed;
    a_words = 16'(v.words);
    a_dout_rdy = 1'b1;
    a_seed_vld = 1'b1;
    tick();
    a_seed_vld = 1'b0;
    lat = 1;
    while (!a_dout_vld && lat < 40) begin
      if (v.poke && lat == 3) begin
        a_seed = ~v.seed;
        a_words = 16'd7;
        a_seed_vld = 1'b1;
        chk("a_seed_rdy_busy", 64'(a_seed_rdy), 64'd0);
      end
      tick();
      a_seed_vld = 1'b0;
      lat++;
    end
    chk("a_latency", 64'(lat), 64'd9);
    got = 0;
    for (int c = 0; c < 200 && got < v.words; c++) begin
      if (a_dout_vld) begin
        if (got == 0) chk("a_first_word", 64'(a_dout), 64'(v.exp_first));
        chk("a_word", 64'(a_dout), pop_exp());
        chk("a_last", 64'(a_dout_last), 64'(got == v.words - 1));
        got++;
      end
      tick();
    end
    chk("a_word_count", 64'(got), 64'(v.words));
    chk("a_seed_rdy_after", 64'(a_seed_rdy), 64'd1);
    chk("a_busy_after", 64'(a_busy), 64'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int lat, got;
    logic [15:0] hold;
    logic [31:0] sd;

    vecs[0] = '{seed: 32'h8000_4000, words: 1, exp_first: 16'h80FF, poke: 1'b0};
    vecs[1] = '{seed: 32'h0000_4000, words: 3, exp_first: 16'h00FF, poke: 1'b0};
    vecs[2] = '{seed: 32'hFFFF_C000, words: 1, exp_first: 16'h01FF, poke: 1'b0};
    vecs[3] = '{seed: 32'h4000_0000, words: 2, exp_first: 16'hFF00, poke: 1'b1};

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_seed_rdy", 64'(a_seed_rdy), 64'd1);
    chk("rst_dout", 64'(a_dout), 64'd0);
    chk("rst_dout_vld", 64'(a_dout_vld), 64'd0);
    chk("rst_dout_last", 64'(a_dout_last), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_b_seed_rdy", 64'(b_seed_rdy), 64'd1);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 4; i++) run_a(vecs[i]);

    // Backpressure in continuous mode
    sd = 32'h1234_5678;
    exp_q.delete();
    gen_expected(sd, 6, 8, 0);
    a_seed = sd;
    a_words = 16'd0;
    a_dout_rdy = 1'b1;
    a_seed_vld = 1'b1;
    tick();
    a_seed_vld = 1'b0;
    wait_a_vld(lat);
    chk("bp_latency", 64'(lat), 64'd9);
    a_dout_rdy = 1'b0;
    hold = a_dout;
    chk("bp_word1", 64'(a_dout), pop_exp());
    for (int c = 0; c < 20; c++) begin
      tick();
      if (a_dout_vld !== 1'b1 || a_dout !== hold || a_dout_last !== 1'b0)
        chk("bp_hold", {31'd0, a_dout_vld, 16'd0, a_dout}, {31'd0, 1'b1, 16'd0, hold});
    end
    chk("bp_hold_final", 64'(a_dout), 64'(hold));
    a_dout_rdy = 1'b1;
    got = 1;
    for (int c = 0; c < 100 && got < 6; c++) begin
      tick();
      if (a_dout_vld) begin
        chk("bp_word", 64'(a_dout), pop_exp());
        chk("bp_last", 64'(a_dout_last), 64'd0);
        got++;
      end
    end
    chk("bp_word_count", 64'(got), 64'd6);

    // Abort with a simultaneous dout handshake
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_vld", 64'(a_dout_vld), 64'd0);
    chk("abort_busy", 64'(a_busy), 64'd0);
    chk("abort_seed_rdy", 64'(a_seed_rdy), 64'd1);
    run_a(vecs[0]);

    // Reset mid-run
    a_seed = 32'hFFFF_1357;
    a_words = 16'd0;
    a_seed_vld = 1'b1;
    tick();
    a_seed_vld = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_vld", 64'(a_dout_vld), 64'd0);
    chk("rst_mid_busy", 64'(a_busy), 64'd0);
    chk("rst_mid_dout", 64'(a_dout), 64'd0);
    chk("rst_mid_seed_rdy", 64'(a_seed_rdy), 64'd1);
    run_a(vecs[1]);

    // Burn-in instance with random seeds
    for (int r = 0; r < 2; r++) begin
      sd = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
      exp_q.delete();
      gen_expected(sd, 2, 32, 100);
      b_seed = sd;
      b_words = 16'd2;
      b_seed_vld = 1'b1;
      tick();
      b_seed_vld = 1'b0;
      lat = 1;
      while (!b_dout_vld && lat < 300) begin
        tick();
        lat++;
      end
      chk("b_latency", 64'(lat), 64'd133);
      got = 0;
      for (int c = 0; c < 200 && got < 2; c++) begin
        if (b_dout_vld) begin
          chk("b_word", b_dout, pop_exp());
          chk("b_last", 64'(b_dout_last), 64'(got == 1));
          got++;
        end
        tick();
      end
      chk("b_word_count", 64'(got), 64'd2);
      chk("b_seed_rdy_after", 64'(b_seed_rdy), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/logistic_seq_mc.md
Name: logistic_seq_mc

Overview:
- Multi-channel, streaming successor to the single-seed logistic chaos generator.
- Runs N_CH independent logistic maps x' = 4x(1-x) in Q0.FRAC_W fixed point.
- Discards a programmable burn-in, then packs the MSB of each iterate into OUT_W-bit words per channel.
- Streams a requested number of words over valid/ready with backpressure; sits between the key/seed source and the scrambler/encryption datapath.

Parameters:
- FRAC_W, 16: state width; x in [0, 2^FRAC_W) represents [0, 1).
- N_CH, 2: number of independent channels (lanes).
- OUT_W, 32: bits per output word per lane.
- BURN_IN, 100: iterations discarded before bit collection; 0 allowed.
- CNT_W, 16: width of the word-count request.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- seed  in  N_CH*FRAC_W  per-lane x0; lane i = seed[i*FRAC_W +: FRAC_W].
- seed_words  in  CNT_W  number of output words to produce; 0 = continuous until abort.
- seed_vld  in  1  seed valid.
- seed_rdy  out  1  seed ready.
- abort  in  1  synchronous stop; return to IDLE, output dropped.
- dout  out  N_CH*OUT_W  packed words; lane i = dout[i*OUT_W +: OUT_W].
- dout_vld  out  1  output valid.
- dout_rdy  in  1  output ready.
- dout_last  out  1  qualifies the final word of a finite request.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: seed_rdy=1, dout=0, dout_vld=0, dout_last=0, busy=0, all x/shift/counters=0, state=IDLE.
- Reset mid-operation discards everything; no partial word is emitted.
- Handshakes: transfer on vld&rdy in the same cycle.
  - seed_rdy=1 only in IDLE with dout_vld=0.
  - dout/dout_last hold stable while dout_vld=1 and dout_rdy=0.
- Iteration per lane: p = x*(2^FRAC_W - x), a 2*FRAC_W+1-bit product.
  - x' = p >> (FRAC_W-2).
  - If x' >= 2^FRAC_W, saturate to 2^FRAC_W-1; this occurs at x=2^(FRAC_W-1).
  - Seed 0 is legal and stays 0; no seed check is performed.
- All lanes iterate in lockstep; one iteration per lane per active cycle.
- FSM states: IDLE, BURN, GEN, DRAIN.
  - IDLE -> BURN on seed handshake (cycle T): load x, latch seed_words, clear counters. Go directly to GEN if BURN_IN=0.
  - BURN: one iteration per cycle; after BURN_IN iterations -> GEN. Burn iterates are not collected.
  - GEN: each iteration shifts the MSB of the new x into the lane shift register LSB, so the first bit ends in the word MSB.
  - On the OUT_W-th bit, the word moves to the dout register with dout_vld=1.
- GEN stall rule: the OUT_W-th iteration of a word is held (x unchanged) while dout_vld=1 and dout_rdy=0. It proceeds in the same cycle the pending word is accepted, giving zero bubbles with dout_rdy held high.
- Throughput: one word per OUT_W cycles.
- Latency: seed handshake at T gives first dout_vld at T+1+BURN_IN+OUT_W.
- Word counter: when the word transferred to dout is number seed_words, set dout_last=1 and enter DRAIN. DRAIN -> IDLE when that word is accepted. For seed_words=0, GEN never terminates and dout_last stays 0.
- abort (any state) -> IDLE next cycle: dout_vld=0, dout_last=0, partial words discarded.
  - abort takes priority over a simultaneous seed or dout handshake; the dout handshake in that cycle is treated as not occurred by the upstream contract.
- seed_vld while busy is ignored (seed_rdy=0).
- Counters: burn counter width $clog2(BURN_IN+1), bit counter $clog2(OUT_W); both wrap to 0 per word/phase.

Test Plan:
- Fixed point: N_CH=2, OUT_W=8, BURN_IN=0, seed={0x8000, 0x4000}, seed_words=1, dout_rdy=1.
  - Required: dout=0x80FF, dout_last=1, dout_vld at T+9.
  - Lane0 goes 0x4000 -> 0xC000 and stays there; lane1 saturates to 0xFFFF, then 3, 11, 43, 171, 682, 2699, 10351.
- Zero seed: seed lane=0, seed_words=3 -> three words of 0x00 in that lane; dout_last only on the 3rd; seed_rdy returns to 1 the cycle after the 3rd transfer.
- Backpressure: continuous mode, dout_rdy low for 20 cycles after the first word.
  - Required: word 1 held stable, x frozen on its final bit.
  - After release, words 2..n match the golden model exactly; no loss or duplication.
- Burn-in: BURN_IN=100, OUT_W=32, FRAC_W=16, random seeds.
  - Required: first dout_vld at T+133.
  - Words match a software model that skips 100 iterates.
- Abort/reset: abort mid-GEN together with dout_vld&dout_rdy -> IDLE, dout_vld=0, busy=0 next cycle; a new seed accepted afterwards restarts cleanly. Repeat using rst_n instead of abort.
- Ignored seed: pulse seed_vld while busy -> no effect; seed_rdy stays 0 and the output sequence is unchanged.
